code_lock: RTL and testbench

CODE_LOCK -- requirements
Module: code_lock

---
 rtl/code_pkg.sv | 28 ++
 rtl/code_timer.sv | 29 ++
 rtl/code_lock.sv | 143 ++++++++++++++
 tb/tb_code_lock.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/code_pkg.sv
// Shared state encodings, default unlock key and duration helpers for code_lock.
// The LOCKOUT encoding exists only when CODE_LOCK_ALARM_EN is defined.
package code_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GOT1    = 3'd1,
    ST_GOT2    = 3'd2,
    ST_OPEN    = 3'd3
`ifdef CODE_LOCK_ALARM_EN
    ,
    ST_LOCKOUT = 3'd4
`endif
  } state_t;

  localparam logic [2:0] KEY0_DEF = 3'b010;
  localparam logic [2:0] KEY1_DEF = 3'b101;
  localparam logic [2:0] KEY2_DEF = 3'b111;

  localparam int CNT_W  = 8;
  localparam int FAIL_W = 4;

  // The timer counts down to zero, so an N-cycle phase is loaded with N-1.
  function automatic logic [CNT_W-1:0] dur_load(input logic [CNT_W-1:0] cycles);
    return (cycles == '0) ? '0 : cycles - 1'b1;
  endfunction

endpackage

// File: rtl/code_timer.sv
// Purpose: 8-bit load/decrement duration counter timing the OPEN and LOCKOUT phases.
// Latency: load takes effect on the next edge; done is combinational from the count.
// Backpressure: none; enable gates counting and the count stops at zero.
module code_timer
  import code_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             enable,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (enable && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/code_lock.sv
// Purpose: three-symbol code lock with timed unlock; CODE_LOCK_ALARM_EN adds failure lockout.
// Latency: fail pulses the cycle after a wrong symbol; unlock/alarm trail their state by one cycle.
// Backpressure: none; code_valid and clear are ignored while OPEN or LOCKOUT.
module code_lock
  import code_pkg::*;
#(
  parameter logic [2:0]        KEY0           = KEY0_DEF,
  parameter logic [2:0]        KEY1           = KEY1_DEF,
  parameter logic [2:0]        KEY2           = KEY2_DEF,
  parameter logic [CNT_W-1:0]  OPEN_CYCLES    = 8'd4,
  parameter logic [FAIL_W-1:0] MAX_FAIL       = 4'd3,
  parameter logic [CNT_W-1:0]  LOCKOUT_CYCLES = 8'd8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] code_in,
  input  logic       code_valid,
  input  logic       clear,
  output logic       unlock,
  output logic       fail,
  output logic       alarm,
  output logic [2:0] state_o
);

  state_t           state, state_nx;
  logic             fail_nx;
  logic [2:0]       want;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_en;
  logic             tmr_done;

`ifdef CODE_LOCK_ALARM_EN
  logic [FAIL_W-1:0] fail_cnt, fail_cnt_nx;
`endif

  always_comb begin
    case (state)
      ST_GOT1: want = KEY1;
      ST_GOT2: want = KEY2;
      default: want = KEY0;
    endcase
  end

  always_comb begin
    state_nx = state;
    fail_nx  = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = dur_load(OPEN_CYCLES);
`ifdef CODE_LOCK_ALARM_EN
    fail_cnt_nx = fail_cnt;
`endif
    case (state)
      ST_IDLE, ST_GOT1, ST_GOT2: begin
        if (clear) begin
          state_nx = ST_IDLE;
        end else if (code_valid) begin
          if (code_in == want) begin
            case (state)
              ST_IDLE: state_nx = ST_GOT1;
              ST_GOT1: state_nx = ST_GOT2;
              default: begin
                state_nx = ST_OPEN;
                tmr_load = 1'b1;
`ifdef CODE_LOCK_ALARM_EN
                fail_cnt_nx = '0;
`endif
              end
            endcase
          end else begin
            fail_nx = 1'b1;
            // A wrong symbol that is itself KEY0 restarts the sequence.
            state_nx = ((state != ST_IDLE) && (code_in == KEY0)) ? ST_GOT1 : ST_IDLE;
`ifdef CODE_LOCK_ALARM_EN
            if (fail_cnt >= MAX_FAIL - 1'b1) begin
              fail_cnt_nx = MAX_FAIL;
              state_nx    = ST_LOCKOUT;
              tmr_load    = 1'b1;
              tmr_val     = dur_load(LOCKOUT_CYCLES);
            end else begin
              fail_cnt_nx = fail_cnt + 1'b1;
            end
`endif
          end
        end
      end
      ST_OPEN: begin
        if (tmr_done) state_nx = ST_IDLE;
      end
`ifdef CODE_LOCK_ALARM_EN
      ST_LOCKOUT: begin
        if (tmr_done) begin
          state_nx    = ST_IDLE;
          fail_cnt_nx = '0;
        end
      end
`endif
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      unlock <= 1'b0;
      fail   <= 1'b0;
    end else begin
      state  <= state_nx;
      unlock <= (state == ST_OPEN);
      fail   <= fail_nx;
    end
  end

`ifdef CODE_LOCK_ALARM_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fail_cnt <= '0;
      alarm    <= 1'b0;
    end else begin
      fail_cnt <= fail_cnt_nx;
      alarm    <= (state == ST_LOCKOUT);
    end
  end

  assign tmr_en = (state == ST_OPEN) || (state == ST_LOCKOUT);
`else
  // Lockout parameters stay on the interface so both builds share one parameter list.
  assign alarm  = 1'b0 & (^{MAX_FAIL, LOCKOUT_CYCLES});
  assign tmr_en = (state == ST_OPEN);
`endif

  code_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .enable   (tmr_en),
    .done     (tmr_done)
  );

  assign state_o = state;

endmodule

// File: tb/tb_code_lock.sv
// Directed scenarios then random traffic on code_lock, checked against a phase-level reference model.
module tb_code_lock;

  localparam logic [2:0] K0     = 3'b010;
  localparam logic [2:0] K1     = 3'b101;
  localparam logic [2:0] K2     = 3'b111;
  localparam int         OPEN_N = 4;
  localparam int         MAXF   = 3;
  localparam int         LOCK_N = 8;
`ifdef CODE_LOCK_ALARM_EN
  localparam bit ALARM_ON = 1'b1;
`else
  localparam bit ALARM_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] code_in = 3'd0;
  logic       code_valid = 1'b0;
  logic       clear = 1'b0;
  logic       unlock, fail, alarm;
  logic [2:0] state_o;

  always #5 clk = ~clk;

  code_lock dut (
    .clk        (clk),
    .reset      (reset),
    .code_in    (code_in),
    .code_valid (code_valid),
    .clear      (clear),
    .unlock     (unlock),
    .fail       (fail),
    .alarm      (alarm),
    .state_o    (state_o)
  );

  // Model: how many key symbols matched, cycles left open/locked, consecutive failures.
  logic [2:0] keys [3];
  int  matched, open_left, lock_left, fails;
  bit  m_unlock, m_fail, m_alarm;
  int  tests, failures, stepno;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s step %0d: got %0d expected %0d", tag, stepno, obs, exp);
    end
  endtask

  task automatic model(input bit r, input bit v, input bit c, input logic [2:0] s);
    bit was_open, was_lock;
    if (r) begin
      matched = 0; open_left = 0; lock_left = 0; fails = 0;
      m_unlock = 0; m_fail = 0; m_alarm = 0;
      return;
    end
    was_open = (open_left > 0);
    was_lock = (lock_left > 0);
    m_unlock = was_open;
    m_alarm  = was_lock;
    m_fail   = 0;
    if (was_open) begin
      open_left--;
    end else if (was_lock) begin
      lock_left--;
      if (lock_left == 0) fails = 0;
    end else if (c) begin
      matched = 0;
    end else if (v) begin
      if (s == keys[matched]) begin
        if (matched == 2) begin
          matched = 0; open_left = OPEN_N; fails = 0;
        end else begin
          matched++;
        end
      end else begin
        m_fail  = 1;
        matched = (matched > 0 && s == K0) ? 1 : 0;
        if (ALARM_ON) begin
          fails++;
          if (fails >= MAXF) begin
            fails = MAXF; matched = 0; lock_left = LOCK_N;
          end
        end
      end
    end
  endtask

  function automatic int exp_state();
    if (open_left > 0) return 3;
    if (lock_left > 0) return 4;
    return matched;
  endfunction

  task automatic step(input bit r, input bit v, input bit c, input logic [2:0] s);
    @(negedge clk);
    reset = r; code_valid = v; clear = c; code_in = s;
    @(posedge clk);
    stepno++;
    model(r, v, c, s);
    #1;
    chk("unlock", {7'd0, unlock}, {7'd0, m_unlock});
    chk("fail", {7'd0, fail}, {7'd0, m_fail});
    chk("alarm", {7'd0, alarm}, {7'd0, m_alarm});
    chk("state_o", {5'd0, state_o}, 8'(exp_state()));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 3'd0);
  endtask

  initial begin
    logic [2:0] sym;
    bit rr, vv, cc;
    keys[0] = K0; keys[1] = K1; keys[2] = K2;
    tests = 0; failures = 0; stepno = 0;
    matched = 0; open_left = 0; lock_left = 0; fails = 0;

    step(1, 0, 0, 3'd0);
    step(1, 1, 0, K0);

    // Correct sequence, open window, return to idle
    step(0, 1, 0, K0); step(0, 1, 0, K1); step(0, 1, 0, K2);
    idle(6);

    // Repeated first key restarts, then opens
    step(0, 1, 0, K0); step(0, 1, 0, K0); step(0, 1, 0, K1); step(0, 1, 0, K2);
    idle(6);

    // Clear beats a simultaneous final key
    step(0, 1, 0, K0); step(0, 1, 0, K1); step(0, 1, 1, K2);
    idle(2);

    // Reset in the second open cycle
    step(0, 1, 0, K0); step(0, 1, 0, K1); step(0, 1, 0, K2);
    step(0, 0, 0, 3'd0);
    step(1, 0, 0, 3'd0);
    idle(2);

    // Wrong symbols: lockout when enabled, plain fail pulses otherwise
    for (int i = 0; i < 5; i++) step(0, 1, 0, 3'b000);
    for (int i = 0; i < 3; i++) step(0, 1, 0, K0);
    idle(10);
    step(0, 1, 0, K0); step(0, 1, 0, K1); step(0, 1, 1, 3'd0);
    idle(2);

    for (int i = 0; i < 1500; i++) begin
      rr  = ($urandom_range(0, 59) == 0);
      vv  = ($urandom_range(0, 9) < 7);
      cc  = ($urandom_range(0, 19) == 0);
      sym = ($urandom_range(0, 9) < 6) ? keys[$urandom_range(0, 2)] : 3'($urandom);
      step(rr, vv, cc, sym);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
